buf_write_arbiter: RTL
======================

Name: buf_write_arbiter

Overview:
- Round-robin write arbiter that shares one circular buffer write port among NUM_REQ producers.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Gates every write on free-space accounting, so the buffer never overruns.
- Sits between the producer front-ends and the buffer's write_en/data inputs; it reads the buffer's fill level back.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: word width; matches the buffer.
- BUFFER_SIZE, 256: buffer depth in words; power of 2.
- MAX_BURST, 16: maximum words per grant (1..BUFFER_SIZE).
- Derived, not overridable: SIZE_WIDTH = log2(BUFFER_SIZE)+1; CNT_WIDTH = log2(MAX_BURST)+1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_REQ  per-requester request; level, held for the whole burst
- i_valid  in  NUM_REQ  per-requester data valid
- i_data  in  NUM_REQ*DATA_WIDTH  packed words; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_buf_size  in  SIZE_WIDTH  buffer fill level, 0..BUFFER_SIZE
- o_grant  out  NUM_REQ  one-hot grant, registered
- o_ack  out  NUM_REQ  word accepted this cycle, combinational
- o_buf_write_en  out  1  buffer write strobe, registered
- o_buf_data  out  DATA_WIDTH  buffer write data, registered
- o_busy  out  1  high in BURST state

Behaviour:
- Reset values:
  - state=IDLE; o_grant=0; o_buf_write_en=0; o_buf_data=0; o_busy=0; burst_cnt=0.
  - last_grant=NUM_REQ-1, so the first arbitration favours requester 0.
  - Reset mid-burst aborts immediately; no write is issued after the reset edge.
- Free space:
  - space_ok = (i_buf_size + o_buf_write_en) < BUFFER_SIZE, computed at SIZE_WIDTH+1 bits with no wrap.
  - The buffer counts a write one cycle after the strobe, so the in-flight write is included.
  - Reads only add space, so this check is conservative.
- IDLE:
  - If i_req != 0, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register o_grant as one-hot for that requester; last_grant = pick; burst_cnt=0; go to BURST.
  - If i_req == 0, stay in IDLE.
- BURST, with g = granted index:
  - o_ack[g] = i_valid[g] & i_req[g] & space_ok; all other o_ack bits are 0. No ack in IDLE.
  - On ack: next cycle o_buf_write_en=1 and o_buf_data=i_data[g]; burst_cnt+1. Otherwise next cycle o_buf_write_en=0 and o_buf_data holds.
  - Release (o_grant=0, go to IDLE) when either:
    - !i_req[g]; or
    - ack and burst_cnt==MAX_BURST-1.
  - Release costs one idle cycle before the next grant. This is the minimum inter-burst gap.
  - Buffer full: stay in BURST with no ack; the grant is held (no timeout). Resume when space_ok.
  - i_valid low with i_req high: hold the grant; no write.
- Latency:
  - i_req rises in cycle 0 → o_grant in cycle 1 → o_ack in cycle 1 if valid and space → o_buf_write_en in cycle 2.
  - Sustained throughput is 1 word/cycle within a burst.
- Simultaneous requests: strict round-robin; a requester that just finished has lowest priority at the next pick.
- i_req/i_valid from non-granted requesters are ignored in BURST.
- A grant never changes mid-word; o_grant is always one-hot or zero.

Optional Feature:
- BUF_ARB_PRIO_EN defined:
  - Requester 0 is strict high priority: in IDLE, if i_req[0] it wins regardless of last_grant.
  - A burst of another requester is still never pre-empted.
  - last_grant is not updated when 0 wins, so the round-robin order among 1..NUM_REQ-1 is preserved.
- Not defined: pure round-robin over all requesters as above.

Test Plan:
- Single requester: i_req[2]=1, i_valid[2]=1, data 0x10..0x1F, i_buf_size=0 → grant at cycle 1; 16 writes 0x10..0x1F on consecutive cycles from cycle 2; release after 16th ack; regrant to 2 after 1 idle cycle if i_req[2] still high.
- All four request continuously, MAX_BURST=16 → grant order 0,1,2,3,0; each burst 16 writes; 1-cycle gap between bursts.
- Full buffer: i_buf_size=255 with a write in flight → o_ack=0 next cycle, grant held; drop i_buf_size to 250 → acks resume; never more than 256 words outstanding.
- Early release: requester 1 drops i_req after 5 acks → exactly 5 writes; IDLE next cycle; next pick starts scan at 2.
- Reset mid-burst after 3 acks → o_grant=0, o_buf_write_en=0 in the same cycle; after release, requests 1 and 3 pending → requester 1 granted first.
- With BUF_ARB_PRIO_EN: requesters 0 and 2 pending continuously → 0 always wins at IDLE; requester 2 is only granted when i_req[0]=0.

Source files
------------

// File: rtl/buf_write_arbiter_if.sv
// Write-arbiter bus: producer requests/data and buffer fill level in,
// grants, acks and the buffer write port out.
// master: producer/buffer side. slave: the arbiter.
interface buf_write_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 256
);
  localparam int SIZE_WIDTH = $clog2(BUFFER_SIZE) + 1;

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ-1:0]            i_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [SIZE_WIDTH-1:0]         i_buf_size;
  logic [NUM_REQ-1:0]            o_grant;
  logic [NUM_REQ-1:0]            o_ack;
  logic                          o_buf_write_en;
  logic [DATA_WIDTH-1:0]         o_buf_data;
  logic                          o_busy;

  modport master (
    output i_req, i_valid, i_data, i_buf_size,
    input  o_grant, o_ack, o_buf_write_en, o_buf_data, o_busy
  );

  modport slave (
    input  i_req, i_valid, i_data, i_buf_size,
    output o_grant, o_ack, o_buf_write_en, o_buf_data, o_busy
  );
endinterface

// File: rtl/buf_write_arbiter.sv
// Round-robin write arbiter sharing one circular-buffer write port among
// NUM_REQ producers, with bursts of up to MAX_BURST words and free-space
// gating against the buffer fill level.
// Optional macro BUF_ARB_PRIO_EN: requester 0 wins every IDLE arbitration
// it takes part in, without disturbing the round-robin pointer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; arbitrate among pending requests
// ST_BURST | one requester granted; ack words while space is available
module buf_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 256,
  parameter int MAX_BURST   = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  buf_write_arbiter_if.slave bus
);
  localparam int SIZE_WIDTH = $clog2(BUFFER_SIZE) + 1;
  localparam int CNT_WIDTH  = $clog2(MAX_BURST) + 1;
  localparam int IDX_WIDTH  = $clog2(NUM_REQ);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IDX_WIDTH-1:0]  gidx_q, gidx_d;
  logic [IDX_WIDTH-1:0]  last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [SIZE_WIDTH:0]   level;
  logic                  space_ok;
  logic [IDX_WIDTH-1:0]  pick;
  logic                  pick_vld;
  logic                  upd_last;
  logic [DATA_WIDTH-1:0] word_g;
  logic                  ack_g;
  logic [NUM_REQ-1:0]    ack_vec;

  // In-flight write counts as occupied: the buffer sees it one cycle late.
  assign level    = {1'b0, bus.i_buf_size} + {{SIZE_WIDTH{1'b0}}, wen_q};
  assign space_ok = level < (SIZE_WIDTH+1)'(BUFFER_SIZE);

  // Round-robin pick: first request after last_q, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = last_q;
    pick_vld = 1'b0;
    upd_last = 1'b1;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (bus.i_req[IDX_WIDTH'(idx)]) begin
        pick     = IDX_WIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
`ifdef BUF_ARB_PRIO_EN
    if (bus.i_req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
      upd_last = 1'b0;
    end
`else
`endif
  end

  // Select the granted requester's data word.
  always_comb begin
    word_g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == IDX_WIDTH'(k)) word_g = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, grant, ack and write-port logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    ack_g   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BURST;
          grant_d = NUM_REQ'(1) << pick;
          gidx_d  = pick;
          cnt_d   = '0;
          if (upd_last) last_d = pick;
        end
      end
      ST_BURST: begin
        ack_g = bus.i_valid[gidx_q] & bus.i_req[gidx_q] & space_ok;
        if (ack_g) begin
          wen_d   = 1'b1;
          wdata_d = word_g;
          cnt_d   = cnt_q + 1'b1;
        end
        if (!bus.i_req[gidx_q] || (ack_g && cnt_q == CNT_WIDTH'(MAX_BURST-1))) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ack_vec = NUM_REQ'(ack_g) << gidx_q;
  end

  // State and output registers; reset aborts any burst at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_WIDTH'(NUM_REQ-1);
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.o_grant        = grant_q;
  assign bus.o_ack          = ack_vec;
  assign bus.o_buf_write_en = wen_q;
  assign bus.o_buf_data     = wdata_q;
  assign bus.o_busy         = (state_q == ST_BURST);
endmodule
